dcmi_capture: RTL

DCMI slave receiver: samples the 8-bit parallel DATA/DSYNC/DCLK bus and captures one frame per arm request into an on-chip FIFO. The FIFO is drained by the SPI-side register logic. It is the receiving end of the DCMI test-pattern master, so a loopback board can check a full frame round trip: generator → pins → capture → SPI readout. DCLK is treated as an asynchronous input and oversampled in the Clk domain.

---
 rtl/dcmi_capture.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dcmi_capture.sv
// dcmi_capture: DCMI slave receiver. Oversamples the asynchronous DCLK/DSYNC/DATA
// bus in the Clk domain, captures one frame per ARM pulse into a first-word
// fall-through FIFO that is drained one byte per RD pulse.
//
// Optional feature macro: DCMI_CAPTURE_CRC_EN (CRC-8, poly 0x07, init 0x00,
// MSB first, no final XOR). When undefined CRC is tied to zero.
//
// Ports:
//   Clk, nRst          clock, asynchronous active-low reset
//   DATA, DSYNC, DCLK  DCMI bus (asynchronous to Clk)
//   ARM                pulse: flush FIFO, clear status, arm next frame
//   RD                 pulse: pop one byte
//   DOUT               FIFO head
//   EMPTY, FULL        FIFO flags
//   BUSY, DONE, OVF    capture status (DONE/OVF sticky until ARM)
//   LEN                bytes in current/last frame, saturating
//   CRC                CRC-8 of the frame bytes
module dcmi_capture #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic [7:0]  DATA,
  input  logic        DSYNC,
  input  logic        DCLK,
  input  logic        ARM,
  input  logic        RD,
  output logic [7:0]  DOUT,
  output logic        EMPTY,
  output logic        FULL,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVF,
  output logic [15:0] LEN,
  output logic [7:0]  CRC
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GAP,
    WAIT_SOF,
    CAPTURE,
    DONE_ST
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    dclk_q;
  logic [1:0]    dsync_q;
  logic [7:0]    data_s1_q, data_s2_q;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    dout_q, dout_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [15:0]   len_q, len_d;

  logic          rise_c, dsync_c, push_c, pop_c, wr_c;
  logic [PW-1:0] rptr_nx_c;

  // Input synchronizers; third DCLK flop is the edge-detect stage
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      dclk_q    <= '0;
      dsync_q   <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      dclk_q    <= {dclk_q[1:0], DCLK};
      dsync_q   <= {dsync_q[0], DSYNC};
      data_s1_q <= DATA;
      data_s2_q <= data_s1_q;
    end
  end

  // DATA/DSYNC come from the same stage as the detected edge
  assign rise_c  = dclk_q[1] & ~dclk_q[2];
  assign dsync_c = dsync_q[1];

  // Next-state logic; ARM overrides everything
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    if (ARM) begin
      state_d = WAIT_GAP;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        WAIT_GAP: if (!dsync_c) state_d = WAIT_SOF;
        WAIT_SOF: if (dsync_c) state_d = CAPTURE;
        CAPTURE: begin
          if (!dsync_c)    state_d = DONE_ST;
          else if (rise_c) push_c  = 1'b1;
        end
        DONE_ST:  state_d = DONE_ST;
        default:  state_d = IDLE;
      endcase
    end
  end

  // FIFO pointer/flag/head and status next-state
  assign pop_c     = RD & ~empty_q;
  assign wr_c      = push_c & (~full_q | pop_c);
  assign rptr_nx_c = rptr_q + PW'(1);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    len_d   = len_q;
    if (ARM) begin
      wptr_d = '0;
      rptr_d = '0;
      dout_d = '0;
      ovf_d  = 1'b0;
      len_d  = '0;
    end else begin
      if (wr_c)  wptr_d = wptr_q + PW'(1);
      if (pop_c) rptr_d = rptr_nx_c;
      // Registered fall-through head: bypass the incoming byte when the
      // FIFO is (or is about to become) empty
      if (pop_c) begin
        if (rptr_nx_c == wptr_q) begin
          if (wr_c) dout_d = data_s2_q;
        end else begin
          dout_d = mem_q[rptr_nx_c[AW-1:0]];
        end
      end else if (wr_c && empty_q) begin
        dout_d = data_s2_q;
      end
      if (push_c && !wr_c)             ovf_d = 1'b1;
      if (push_c && len_q != 16'hFFFF) len_d = len_q + 16'd1;
    end
    empty_d = (rptr_d == wptr_d);
    full_d  = (rptr_d[AW-1:0] == wptr_d[AW-1:0]) && (rptr_d[AW] != wptr_d[AW]);
    busy_d  = (state_d == WAIT_GAP) || (state_d == WAIT_SOF) || (state_d == CAPTURE);
    done_d  = (state_d == DONE_ST);
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dout_q  <= dout_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      len_q   <= len_d;
    end
  end

  // Storage array, not reset; contents are only visible through the pointers
  always_ff @(posedge Clk) begin
    if (wr_c) mem_q[wptr_q[AW-1:0]] <= data_s2_q;
  end

`ifdef DCMI_CAPTURE_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // CRC counts every received byte, including those dropped on overflow
  always_comb begin
    crc_d = crc_q;
    if (ARM)         crc_d = '0;
    else if (push_c) crc_d = crc8_byte(crc_q, data_s2_q);
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign CRC = crc_q;
`else
  assign CRC = 8'h00;
`endif

  assign DOUT  = dout_q;
  assign EMPTY = empty_q;
  assign FULL  = full_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign OVF   = ovf_q;
  assign LEN   = len_q;

endmodule
